// File: rtl/acc_pkg.sv
// Shared types and default constants for the adaptive cruise controller.
package acc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MANUAL = 3'd1,
    ST_CRUISE = 3'd2,
    ST_FOLLOW = 3'd3,
    ST_BRAKE  = 3'd4
  } acc_state_t;

  localparam int DEF_SPEED_W       = 8;
  localparam int DEF_MIN_SET_SPEED = 45;
  localparam int DEF_MAX_SPEED     = 200;
  localparam int DEF_ACCEL_STEP    = 1;
  localparam int DEF_DRAG_STEP     = 1;
  localparam int DEF_BRAKE_STEP    = 2;

endpackage

// File: rtl/acc_speed_step.sv
// Combinational step of a value toward a target: up by up_step or down by
// down_step, clamped so the result never passes the target.
module acc_speed_step #(
  parameter int W = 8
) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] target,
  input  logic [W-1:0] up_step,
  input  logic [W-1:0] down_step,
  output logic [W-1:0] nxt
);

  // One extra bit keeps the sum and the floor comparison free of wrap-around.
  logic [W:0] up_sum;
  logic [W:0] down_floor;

  assign up_sum     = {1'b0, cur} + {1'b0, up_step};
  assign down_floor = {1'b0, target} + {1'b0, down_step};

  always_comb begin
    nxt = cur;
    if (cur < target) begin
      nxt = (up_sum >= {1'b0, target}) ? target : up_sum[W-1:0];
    end else if (cur > target) begin
      nxt = ({1'b0, cur} >= down_floor) ? (cur - down_step) : target;
    end
  end

endmodule

// File: rtl/adaptive_cruise_control.sv
// Adaptive cruise controller: driver-mode FSM with a vehicle speed model,
// a stored set-point and lead-vehicle following.
module adaptive_cruise_control
  import acc_pkg::*;
#(
  parameter int SPEED_W       = DEF_SPEED_W,
  parameter int MIN_SET_SPEED = DEF_MIN_SET_SPEED,
  parameter int MAX_SPEED     = DEF_MAX_SPEED,
  parameter int ACCEL_STEP    = DEF_ACCEL_STEP,
  parameter int DRAG_STEP     = DEF_DRAG_STEP,
  parameter int BRAKE_STEP    = DEF_BRAKE_STEP
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               throttle,
  input  logic               set,
  input  logic               accel,
  input  logic               coast,
  input  logic               cancel,
  input  logic               resume,
  input  logic               brake,
  input  logic               lead_valid,
  input  logic [SPEED_W-1:0] lead_speed,
  output logic [SPEED_W-1:0] speed,
  output logic [SPEED_W-1:0] cruise_speed,
  output logic               cruise_status,
  output logic [2:0]         state
);

  localparam longint RANGE = longint'(1) << SPEED_W;

  generate
    if (!(MIN_SET_SPEED >= 0 && MIN_SET_SPEED <= MAX_SPEED && MAX_SPEED < RANGE &&
          ACCEL_STEP >= 1 && DRAG_STEP >= 1 && BRAKE_STEP >= 1 &&
          ACCEL_STEP < RANGE && DRAG_STEP < RANGE && BRAKE_STEP < RANGE)) begin : g_param_check
      $error("adaptive_cruise_control: illegal speed/step parameters");
    end
  endgenerate

  localparam logic [SPEED_W-1:0] MAX_V   = SPEED_W'(MAX_SPEED);
  localparam logic [SPEED_W-1:0] MIN_V   = SPEED_W'(MIN_SET_SPEED);
  localparam logic [SPEED_W-1:0] ACCEL_V = SPEED_W'(ACCEL_STEP);
  localparam logic [SPEED_W-1:0] DRAG_V  = SPEED_W'(DRAG_STEP);
  localparam logic [SPEED_W-1:0] BRAKE_V = SPEED_W'(BRAKE_STEP);

  acc_state_t         state_reg, state_next;
  logic [SPEED_W-1:0] speed_reg, speed_next;
  logic [SPEED_W-1:0] cruise_speed_reg, cruise_speed_next;
  logic               cs_valid_reg, cs_valid_next;
  logic               cruise_status_reg;

  logic [SPEED_W-1:0] spd_target, spd_down;
  logic [SPEED_W-1:0] cs_target, cs_stepped;
  logic               cs_load, cs_adjust, lead_closer;

  assign lead_closer = lead_valid && (lead_speed < cruise_speed_reg);

  always_comb begin
    state_next    = state_reg;
    spd_target    = speed_reg;
    spd_down      = DRAG_V;
    cs_load       = 1'b0;
    cs_valid_next = cs_valid_reg;
    case (state_reg)
      ST_IDLE: begin
        state_next = ST_MANUAL;
      end
      ST_MANUAL: begin
        spd_target = throttle ? MAX_V : '0;
        if (brake) begin
          state_next = ST_BRAKE;
        end else if (set && speed_reg >= MIN_V) begin
          state_next    = ST_CRUISE;
          cs_load       = 1'b1;
          cs_valid_next = 1'b1;
        end else if (resume && cs_valid_reg) begin
          state_next = ST_CRUISE;
        end
      end
      ST_CRUISE: begin
        spd_target = throttle ? MAX_V : cruise_speed_reg;
        if (brake)            state_next = ST_BRAKE;
        else if (cancel)      state_next = ST_MANUAL;
        else if (lead_closer) state_next = ST_FOLLOW;
      end
      ST_FOLLOW: begin
        // An invalid lead reading is ignored, so the target falls back to the set-point.
        spd_target = throttle ? MAX_V : (lead_closer ? lead_speed : cruise_speed_reg);
        if (brake)             state_next = ST_BRAKE;
        else if (cancel)       state_next = ST_MANUAL;
        else if (!lead_closer) state_next = ST_CRUISE;
      end
      ST_BRAKE: begin
        spd_target = '0;
        spd_down   = BRAKE_V;
        if (!brake) state_next = ST_MANUAL;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  acc_speed_step #(.W(SPEED_W)) u_speed_step (
    .cur       (speed_reg),
    .target    (spd_target),
    .up_step   (ACCEL_V),
    .down_step (spd_down),
    .nxt       (speed_next)
  );

  // Set-point adjustment reuses the stepper with the saturation bound as target.
  assign cs_target = accel ? MAX_V : MIN_V;
  assign cs_adjust = (state_reg == ST_CRUISE || state_reg == ST_FOLLOW) && (accel ^ coast);

  acc_speed_step #(.W(SPEED_W)) u_cs_step (
    .cur       (cruise_speed_reg),
    .target    (cs_target),
    .up_step   (ACCEL_V),
    .down_step (ACCEL_V),
    .nxt       (cs_stepped)
  );

  always_comb begin
    cruise_speed_next = cruise_speed_reg;
    if (cs_load)        cruise_speed_next = speed_reg;
    else if (cs_adjust) cruise_speed_next = cs_stepped;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg         <= ST_IDLE;
      speed_reg         <= '0;
      cruise_speed_reg  <= '0;
      cs_valid_reg      <= 1'b0;
      cruise_status_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      speed_reg         <= speed_next;
      cruise_speed_reg  <= cruise_speed_next;
      cs_valid_reg      <= cs_valid_next;
      cruise_status_reg <= (state_next == ST_CRUISE) || (state_next == ST_FOLLOW);
    end
  end

  assign speed         = speed_reg;
  assign cruise_speed  = cruise_speed_reg;
  assign cruise_status = cruise_status_reg;
  assign state         = state_reg;

endmodule

// File: doc/adaptive_cruise_control.md
ADAPTIVE_CRUISE_CONTROL -- requirements
Module: adaptive_cruise_control

Interface
REQ-001 Parameter SPEED_W, default 8: width of all speed values.
REQ-002 Parameter MIN_SET_SPEED, default 45: lowest speed at which set may engage and lowest cruise_speed.
REQ-003 Parameter MAX_SPEED, default 200: saturation ceiling for speed and cruise_speed.
REQ-004 Parameters ACCEL_STEP, DRAG_STEP and BRAKE_STEP, defaults 1, 1 and 2: per-cycle speed change under throttle, coasting and braking.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-006 clock  in  1  rising-edge clock.
REQ-007 reset  in  1  asynchronous active-low reset.
REQ-008 throttle, set, accel, coast, cancel, resume, brake  in  1 each  driver controls, synchronous to clock.
REQ-009 lead_valid  in  1  lead vehicle detected.
REQ-010 lead_speed  in  SPEED_W  lead vehicle speed, qualified by lead_valid.
REQ-011 speed  out  SPEED_W  current vehicle speed, registered.
REQ-012 cruise_speed  out  SPEED_W  stored set-point, registered.
REQ-013 cruise_status  out  1  high in CRUISE or FOLLOW, registered.
REQ-014 state  out  3  encoded current state, for debug.

Function
REQ-015 The states SHALL be IDLE, MANUAL, CRUISE, FOLLOW and BRAKE.
REQ-016 IDLE SHALL go to MANUAL on the first clock after reset deasserts.
REQ-017 MANUAL transition priority SHALL be:
- brake -> BRAKE;
- set with speed>=MIN_SET_SPEED -> CRUISE, loading cruise_speed<=speed and cs_valid<=1;
- resume with cs_valid=1 -> CRUISE, cruise_speed unchanged;
- otherwise stay in MANUAL.
REQ-018 CRUISE transition priority SHALL be: brake -> BRAKE; cancel -> MANUAL; lead_valid with lead_speed<cruise_speed -> FOLLOW; otherwise stay.
REQ-019 FOLLOW transition priority SHALL be: brake -> BRAKE; cancel -> MANUAL; lead_valid=0 or lead_speed>=cruise_speed -> CRUISE; otherwise stay.
REQ-020 BRAKE SHALL stay while brake=1 and go to MANUAL when brake=0.
REQ-021 Speed update in MANUAL: throttle -> speed+ACCEL_STEP, saturated at MAX_SPEED; otherwise speed-DRAG_STEP, floored at 0.
REQ-022 Speed update in CRUISE and FOLLOW:
- throttle -> +ACCEL_STEP, saturated;
- otherwise step toward the target, up by ACCEL_STEP or down by DRAG_STEP, landing exactly on the target with no overshoot.
REQ-023 The target SHALL be cruise_speed in CRUISE and min(lead_speed, cruise_speed) in FOLLOW.
REQ-024 Speed update in BRAKE: speed-BRAKE_STEP, floored at 0; throttle is ignored.
REQ-025 Set-point adjustment in CRUISE and FOLLOW:
- accel alone -> cruise_speed+ACCEL_STEP, saturated at MAX_SPEED;
- coast alone -> cruise_speed-ACCEL_STEP, floored at MIN_SET_SPEED;
- accel and coast together -> no change.
REQ-026 cs_valid SHALL be cleared only by reset, so the set-point survives cancel and brake.
REQ-027 Every state change, speed update and cruise_speed update SHALL take effect at the same rising edge, with one-cycle latency from input to output.
REQ-028 All saturating arithmetic SHALL use a SPEED_W+1-bit intermediate so that no wrap-around can occur.
REQ-029 Elaboration SHALL fail unless MIN_SET_SPEED<=MAX_SPEED<2^SPEED_W and every step value is at least 1.

Reset
REQ-030 While reset=0, the block SHALL hold state=IDLE, speed=0, cruise_speed=0, cruise_status=0 and cs_valid=0, regardless of clock.
REQ-031 Reset asserted mid-CRUISE SHALL immediately clear all outputs.
REQ-032 After reset deasserts, resume SHALL NOT engage cruise until a new set has been accepted.

Structure
REQ-033 Package acc_pkg SHALL hold the state enum typedef, the state encodings and the default parameter constants.
REQ-034 Sub-module acc_speed_step SHALL implement the combinational saturating step-toward-target, instanced for speed and reused for cruise_speed adjustment.

Verification
REQ-035 Reset release, throttle held for 50 cycles, then set for 1 cycle -> speed=50, CRUISE entered, cruise_speed=50, cruise_status=1.
REQ-036 Set pulsed with speed=44 -> state remains MANUAL, cruise_speed unchanged.
REQ-037 In CRUISE at 60, lead_valid=1 with lead_speed=55 -> FOLLOW next cycle; speed reaches 55 after 5 cycles; dropping lead_valid returns to CRUISE and speed reaches 60 after 5 more cycles.
REQ-038 In CRUISE at 60, brake held 3 cycles then released -> speed=54 and MANUAL; resume then re-enters CRUISE with cruise_speed=60.
REQ-039 In CRUISE with cruise_speed=199, accel for 3 cycles -> cruise_speed=200; coast at cruise_speed=45 -> stays 45; accel and coast together -> no change.
REQ-040 reset=0 asserted asynchronously mid-FOLLOW -> all outputs 0 before the next clock edge; resume after release -> state stays MANUAL.
